alarm_scheduler: RTL

Multi-channel alarm scheduler for the femto peripheral bus. It shares one clock prescaler among `NCH` independent countdown channels and sequences their decrements. Each channel latches a pending flag when it expires, and a single level interrupt is raised to the core. It sits beside the single-channel timer controller as the peripheral software uses for multiple concurrent deadlines.

---
 rtl/alarm_scheduler_pkg.sv | 25 ++
 rtl/alarm_scheduler_channel.sv | 46 ++++
 rtl/alarm_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alarm_scheduler_pkg.sv
// Shared constants for the femto-bus alarm scheduler: bus widths, access sizes
// and the register-map offsets of the alarm block.
package alarm_scheduler_pkg;

    localparam int BUS_WIDTH     = 32;
    localparam int BUS_ACC_WIDTH = 2;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

    localparam int TMR_DIV      = 16;
    localparam int CNT_WIDTH    = 32;
    localparam int ALM_VA_WIDTH = 5;
    localparam int ALM_NCH_MAX  = 6;

    localparam logic [ALM_VA_WIDTH-1:0] ALM_CH = 5'h00;

    // STAT and EN sit directly after the last channel register.
    function automatic logic [ALM_VA_WIDTH-1:0] alm_stat(input int nch);
        return ALM_CH + 5'(4 * nch);
    endfunction

    function automatic logic [ALM_VA_WIDTH-1:0] alm_en(input int nch);
        return ALM_CH + 5'(4 * nch + 4);
    endfunction

endpackage

// File: rtl/alarm_scheduler_channel.sv
// One alarm channel: a loadable down-counter that decrements on shared ticks
// and latches a pending flag when it moves from 1 to 0.
module alarm_channel
    import alarm_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld,
    input  logic [CNT_WIDTH-1:0] ld_val,
    input  logic                 en,
    input  logic                 tick,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 pend,
    output logic                 active
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_pend;
    logic                 w_dec;

    assign active = en & (r_cnt != '0);
    // A bus load in a tick cycle takes precedence over the decrement.
    assign w_dec  = tick & active & ~ld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (ld)
                r_cnt <= ld_val;
            else if (w_dec)
                r_cnt <= r_cnt - 1'b1;

            if (w_dec && (r_cnt == CNT_WIDTH'(1)))
                r_pend <= 1'b1;
            else if (clr)
                r_pend <= 1'b0;
        end
    end

    assign cnt  = r_cnt;
    assign pend = r_pend;

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-channel alarm scheduler: NCH countdown channels sharing one prescaler,
// with W1C pending flags, per-channel irq enables and a femto-bus register file.
module alarm_scheduler
    import alarm_scheduler_pkg::*;
#(
    parameter int DIV = TMR_DIV,
    parameter int NCH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ALM_VA_WIDTH-1:0]  addr,
    input  logic                     w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] acc,
    output logic [BUS_WIDTH-1:0]     rdata,
    input  logic [BUS_WIDTH-1:0]     wdata,
    input  logic                     req,
    output logic                     resp,
    output logic                     fault,
    output logic                     irq
);

    if (NCH < 1 || NCH > ALM_NCH_MAX) begin : g_bad_nch
        $error("alarm_scheduler: NCH out of range");
    end
    if (DIV < 1 || DIV > 65536) begin : g_bad_div
        $error("alarm_scheduler: DIV out of range");
    end

    localparam logic [15:0]             DIV_M1   = 16'(DIV - 1);
    localparam logic [ALM_VA_WIDTH-1:0] OFF_STAT = alm_stat(NCH);
    localparam logic [ALM_VA_WIDTH-1:0] OFF_EN   = alm_en(NCH);

    logic [15:0]          r_div;
    logic [NCH-1:0]       r_en;
    logic                 r_resp;
    logic [BUS_WIDTH-1:0] r_rdata;

    logic [2:0]           w_idx;
    logic                 w_is_ch;
    logic                 w_is_stat;
    logic                 w_is_en;
    logic                 w_invld;
    logic                 w_vld;
    logic                 w_wr;
    logic                 w_any_active;
    logic                 w_tick;
    logic [NCH-1:0]       w_ld;
    logic [NCH-1:0]       w_clr;
    logic [NCH-1:0]       w_pend;
    logic [NCH-1:0]       w_active;
    logic [CNT_WIDTH-1:0] w_cnt [NCH];
    logic [BUS_WIDTH-1:0] w_rd;

    assign w_idx     = addr[4:2];
    assign w_is_ch   = (addr < OFF_STAT);
    assign w_is_stat = (addr == OFF_STAT);
    assign w_is_en   = (addr == OFF_EN);
    assign w_invld   = (addr[1:0] != 2'b00) | (acc != BUS_ACC_4B)
                     | ~(w_is_ch | w_is_stat | w_is_en);
    assign fault     = req & w_invld;
    assign w_vld     = req & ~w_invld;
    assign w_wr      = w_vld & w_rb;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_ld[i]  = w_wr & w_is_ch & (w_idx == 3'(i));
        assign w_clr[i] = w_wr & w_is_stat & wdata[i];

        alarm_channel u_ch (
            .clk    (clk),
            .rst    (rst),
            .ld     (w_ld[i]),
            .ld_val (wdata),
            .en     (r_en[i]),
            .tick   (w_tick),
            .clr    (w_clr[i]),
            .cnt    (w_cnt[i]),
            .pend   (w_pend[i]),
            .active (w_active[i])
        );
    end

    assign w_any_active = |w_active;
    assign w_tick       = w_any_active & (r_div == 16'd0);

    always_comb begin
        w_rd = '0;
        if (w_is_stat)
            w_rd[NCH-1:0] = w_pend;
        else if (w_is_en)
            w_rd[NCH-1:0] = r_en;
        else
            for (int i = 0; i < NCH; i++)
                if (w_idx == 3'(i))
                    w_rd = w_cnt[i];
    end

    // The prescaler only restarts when every channel is idle, so loading one
    // channel never shifts the tick phase seen by the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= DIV_M1;
            r_en    <= '0;
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (!w_any_active || r_div == 16'd0)
                r_div <= DIV_M1;
            else
                r_div <= r_div - 16'd1;

            if (w_wr && w_is_en)
                r_en <= wdata[NCH-1:0];

            r_resp <= w_vld;
            if (w_vld && !w_rb)
                r_rdata <= w_rd;
        end
    end

    assign resp  = r_resp;
    assign rdata = r_rdata;
    assign irq   = |(w_pend & r_en);

endmodule
